// File: rtl/fir_decim_pkg.sv
// Shared constants and state type for the decimating FIR sequencer.
// Sizes of ring, frame, FIFO and MAC pipeline live here.
package fir_decim_pkg;

   localparam int DW      = 192;
   localparam int AW      = 5;
   localparam int NMAC    = 16;
   localparam int DECIM   = 4;
   localparam int FDEPTH  = 8;
   localparam int MAC_LAT = 4;
   localparam int PW      = $clog2(NMAC);
   localparam int CW      = $clog2(FDEPTH) + 1;
   localparam int WSTEP   = NMAC / DECIM;

   typedef enum logic {IDLE, RUN} state_t;

endpackage

// File: rtl/fir_decim_ctrl_fifo.sv
// Input word FIFO with occupancy count.
// The head word is read straight from the storage registers.
module sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic [CW-1:0] count,
   output logic          full
);

   localparam int PTW = $clog2(DEPTH);

   logic [W-1:0]   mem [DEPTH];
   logic [PTW-1:0] wptr;
   logic [PTW-1:0] rptr;
   logic           wr;

   // a push into a full FIFO is refused even if a pop happens too
   assign full = (count == CW'(DEPTH));
   assign wr   = push && !full;
   assign dout = mem[rptr];

   // storage write
   always_ff @(posedge clk) begin
      if (wr) mem[wptr] <= din;
   end

   // pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr)  wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         count <= count + CW'(wr) - CW'(pop);
      end
   end

endmodule

// File: rtl/fir_decim_ctrl.sv
// Frame sequencer for the 8-ch decimate-by-4 symmetric FIR.
// FIR_DECIM_CTRL_STATS_EN adds the starvation counter ports.
module fir_decim_ctrl
   import fir_decim_pkg::*;
(
   input  logic          c,
   input  logic          reset_n,
   input  logic          en,
`ifdef FIR_DECIM_CTRL_STATS_EN
   input  logic          stats_clr,
   output logic [15:0]   stall_cnt,
`endif
   input  logic [DW-1:0] s_data,
   input  logic          s_valid,
   output logic          s_ready,
   output logic          ram_w,
   output logic [AW-1:0] ram_wa,
   output logic [DW-1:0] ram_wd,
   output logic [AW-1:0] ram_ra0,
   output logic [AW-1:0] ram_ra1,
   output logic [3:0]    coef_addr,
   output logic          mac_first,
   output logic          busy,
   output logic          ov
);

   state_t          state;
   state_t          state_n;
   logic [PW-1:0]   phase;
   logic [PW-1:0]   phase_n;
   logic [AW-1:0]   wa;
   logic [AW-1:0]   wa0;
   logic [CW-1:0]   count;
   logic            full;
   logic [DW-1:0]   head;
   logic            start;
   logic            last;
   logic            run_n;
   logic            wr_n;
   logic [MAC_LAT:0] dl;

   sync_fifo #(
      .W     (DW),
      .DEPTH (FDEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk   (c),
      .rst_n (reset_n),
      .push  (s_valid),
      .din   (s_data),
      .pop   (ram_w),
      .dout  (head),
      .count (count),
      .full  (full)
   );

   assign s_ready = !full;
   assign start   = en && (count >= CW'(DECIM));
   assign last    = (state == RUN) && (phase == PW'(NMAC - 1));
   assign busy    = (state == RUN);
   assign ov      = dl[MAC_LAT];

   // frame sequencing: phase runs only in RUN
   always_comb begin
      state_n = state;
      phase_n = '0;
      case (state)
         IDLE: if (start) state_n = RUN;
         RUN: begin
            if (phase != PW'(NMAC - 1)) phase_n = phase + 1'b1;
            else if (!start)            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // outputs are loaded with the values for the coming issue cycle
   assign run_n = (state_n == RUN);
   assign wr_n  = run_n &&
                  ((phase_n & PW'(WSTEP - 1)) == PW'(1));

   // state register
   always_ff @(posedge c or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         phase <= '0;
      end else begin
         state <= state_n;
         phase <= phase_n;
      end
   end

   // address generator, ring write port and FIFO pop
   always_ff @(posedge c or negedge reset_n) begin
      if (!reset_n) begin
         ram_w     <= 1'b0;
         ram_wa    <= '0;
         ram_wd    <= '0;
         ram_ra0   <= '0;
         ram_ra1   <= '0;
         coef_addr <= '0;
         mac_first <= 1'b0;
         wa        <= '0;
         wa0       <= '0;
      end else begin
         ram_w <= wr_n;
         if (wr_n) begin
            ram_wa <= wa;
            ram_wd <= head;
         end
         if (ram_w) wa <= wa + 1'b1;
         if (run_n) begin
            coef_addr <= phase_n;
            mac_first <= (phase_n == '0);
            if (phase_n == '0) begin
               wa0     <= wa;
               ram_ra0 <= wa;
               ram_ra1 <= wa - 1'b1;
            end else begin
               ram_ra0 <= wa0 + AW'(phase_n);
               ram_ra1 <= wa0 - 1'b1 - AW'(phase_n);
            end
         end
      end
   end

   // MAC result delay line; ov marks the finished accumulation
   always_ff @(posedge c or negedge reset_n) begin
      if (!reset_n) dl <= '0;
      else          dl <= {dl[MAC_LAT-1:0], last};
   end

`ifdef FIR_DECIM_CTRL_STATS_EN
   // saturating count of idle cycles starved of input words
   always_ff @(posedge c or negedge reset_n) begin
      if (!reset_n)
         stall_cnt <= '0;
      else if (stats_clr)
         stall_cnt <= '0;
      else if (state == IDLE && en &&
               count < CW'(DECIM) &&
               stall_cnt != 16'hFFFF)
         stall_cnt <= stall_cnt + 1'b1;
   end
`endif

endmodule
